apb_slave_if: RTL and testbench



---
 rtl/apb_slave_if.sv | 149 ++++++++++++++
 tb/tb_apb_slave_if.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_slave_if.sv
// APB3 slave front-end for the timer register block: converts APB setup/access
// phases into single-cycle register-file strobes and returns registered read data.
module apb_slave_if #(
    parameter int                ADDR_W      = 10,
    parameter int                DATA_W      = 32,
    parameter int                WAIT_CYCLES = 0,
    parameter logic [ADDR_W-1:0] ADDR_MAX    = 10'h00C
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [DATA_W-1:0] pwdata,
    output logic              pready,
    output logic [DATA_W-1:0] prdata,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACC, S_RESP, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] prdata_q, prdata_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic              pready_q, pready_d;
    logic              pslverr_q, pslverr_d;
    logic              setup;
    logic              addr_err;

    assign setup    = psel && !penable;
    assign addr_err = (paddr[1:0] != 2'b00) || (paddr > ADDR_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (setup) state_d = S_WAIT;
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACC;
                end
            end
            S_ACC:   state_d = S_RESP;
            S_RESP:  state_d = S_DONE;
            // DONE spends one cycle raising pready and one cycle showing it
            S_DONE:  if (pready_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        err_d     = err_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        prdata_d  = prdata_q;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (setup) begin
                    addr_d = paddr;
                    wr_d   = pwrite;
                    err_d  = addr_err;
                    cnt_d  = 4'(WAIT_CYCLES);
                    if (pwrite) wdata_d = pwdata;
                end
            end
            S_WAIT: begin
                if (psel) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        wr_en_d = wr_q && !err_q;
                        rd_en_d = !wr_q && !err_q;
                    end
                end
            end
            // rdata answers the strobe one cycle later, so it is valid here
            S_RESP: prdata_d = (wr_q || err_q) ? '0 : rdata;
            S_DONE: begin
                if (!pready_q) begin
                    pready_d  = 1'b1;
                    pslverr_d = err_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            prdata_q  <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            prdata_q  <= prdata_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;
    assign wr_en   = wr_en_q;
    assign rd_en   = rd_en_q;
    assign addr    = addr_q;
    assign wdata   = wdata_q;

endmodule

// File: tb/tb_apb_slave_if.sv
// Bench for apb_slave_if: two instances (0 and 3 wait states) driven by an APB
// master task, checked every cycle against a transfer-timeline reference model.
module tb_apb_slave_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        chk_on = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [9:0]  paddr   [2];
    logic [31:0] pwdata  [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic [9:0]  addr    [2];
    logic [31:0] wdata   [2];
    logic [31:0] rdata   [2];
    logic [31:0] rf_mem  [2][4];

    // reference model state: one transfer per lane, k = edges since its setup edge
    bit          m_act   [2];
    int          m_k     [2];
    bit          m_wr    [2];
    bit          m_err   [2];
    logic [9:0]  m_addr  [2];
    logic [31:0] m_wdata [2];
    logic [31:0] m_prdata[2];
    logic [31:0] exp_mem [2][4];

    int          r_strb_j, r_strb_cnt, r_rdy_j;
    bit          r_strb_rd, r_pslverr;
    logic [9:0]  r_strb_addr;
    logic [31:0] r_strb_wdata, r_prdata;

    always #5 clk = ~clk;

    apb_slave_if #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0), .ADDR_MAX(10'h00C)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .prdata(prdata[0]),
        .pslverr(pslverr[0]), .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]),
        .wdata(wdata[0]), .rdata(rdata[0]));

    apb_slave_if #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(3), .ADDR_MAX(10'h00C)) dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .prdata(prdata[1]),
        .pslverr(pslverr[1]), .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]),
        .wdata(wdata[1]), .rdata(rdata[1]));

    function automatic int wc(input int l);
        return (l == 0) ? 0 : 3;
    endfunction

    function automatic logic [31:0] seed(input int i);
        case (i)
            1:       return 32'h12345678;
            3:       return 32'hC0DE000C;
            default: return 32'hA5A50000 | 32'(i);
        endcase
    endfunction

    task automatic chk(input string name, input int l, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, l, $time, act, exp);
        end
    endtask

    // register file: write on wr_en, registered read data one cycle after rd_en
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                rdata[l] <= '0;
                for (int i = 0; i < 4; i++) rf_mem[l][i] <= seed(i);
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (wr_en[l]) rf_mem[l][addr[l][3:2]] <= wdata[l];
                if (rd_en[l]) rdata[l] <= rf_mem[l][addr[l][3:2]];
            end
        end
    end

    // reference model: strobe at k=W+1, write lands at W+2, prdata at W+3,
    // pready at W+4, idle again after W+5; psel low during k<=W+1 aborts
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                m_act[l]    <= 1'b0;
                m_k[l]      <= 0;
                m_wr[l]     <= 1'b0;
                m_err[l]    <= 1'b0;
                m_addr[l]   <= '0;
                m_wdata[l]  <= '0;
                m_prdata[l] <= '0;
                for (int i = 0; i < 4; i++) exp_mem[l][i] <= seed(i);
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (m_act[l]) begin
                    m_k[l] <= m_k[l] + 1;
                    if ((m_k[l] + 1) <= wc(l) + 1 && !psel[l]) m_act[l] <= 1'b0;
                    if ((m_k[l] + 1) == wc(l) + 2 && m_wr[l] && !m_err[l])
                        exp_mem[l][m_addr[l][3:2]] <= m_wdata[l];
                    if ((m_k[l] + 1) == wc(l) + 3)
                        m_prdata[l] <= (m_wr[l] || m_err[l]) ? 32'd0 : exp_mem[l][m_addr[l][3:2]];
                    if ((m_k[l] + 1) == wc(l) + 5) m_act[l] <= 1'b0;
                end else if (psel[l] && !penable[l]) begin
                    m_act[l]  <= 1'b1;
                    m_k[l]    <= 0;
                    m_wr[l]   <= pwrite[l];
                    m_err[l]  <= (paddr[l][1:0] != 2'b00) || (paddr[l] > 10'h00C);
                    m_addr[l] <= paddr[l];
                    if (pwrite[l]) m_wdata[l] <= pwdata[l];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int l = 0; l < 2; l++) begin
                chk("wr_en", l, 64'(wr_en[l]), 64'(m_act[l] && m_k[l] == wc(l) + 1 && m_wr[l] && !m_err[l]));
                chk("rd_en", l, 64'(rd_en[l]), 64'(m_act[l] && m_k[l] == wc(l) + 1 && !m_wr[l] && !m_err[l]));
                chk("pready", l, 64'(pready[l]), 64'(m_act[l] && m_k[l] == wc(l) + 4));
                chk("pslverr", l, 64'(pslverr[l]), 64'(m_act[l] && m_k[l] == wc(l) + 4 && m_err[l]));
                chk("prdata", l, 64'(prdata[l]), 64'(m_prdata[l]));
                chk("addr", l, 64'(addr[l]), 64'(m_addr[l]));
                chk("wdata", l, 64'(wdata[l]), 64'(m_wdata[l]));
            end
        end
    end

    task automatic xfer(input int l, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input int hold, input int abort_at);
        r_strb_j = -1; r_strb_cnt = 0; r_rdy_j = -1; r_strb_rd = 1'b0; r_pslverr = 1'b0;
        r_strb_addr = '0; r_strb_wdata = '0; r_prdata = '0;
        psel[l] = 1'b1; penable[l] = 1'b0; pwrite[l] = wr; paddr[l] = a; pwdata[l] = d;
        for (int h = 0; h < hold; h++) @(negedge clk);
        penable[l] = 1'b1;
        pwrite[l]  = 1'($urandom_range(0, 1));
        paddr[l]   = 10'($urandom);
        pwdata[l]  = $urandom;
        for (int j = 1; j <= 40 && r_rdy_j < 0; j++) begin
            if (j == abort_at) begin
                psel[l] = 1'b0; penable[l] = 1'b0;
            end
            @(negedge clk);
            if (wr_en[l] || rd_en[l]) begin
                r_strb_cnt++;
                if (r_strb_j < 0) begin
                    r_strb_j = j; r_strb_rd = rd_en[l];
                    r_strb_addr = addr[l]; r_strb_wdata = wdata[l];
                end
            end
            if (pready[l]) begin
                r_rdy_j = j; r_prdata = prdata[l]; r_pslverr = pslverr[l];
            end
            if (abort_at > 0 && j >= abort_at + wc(l) + 6) break;
        end
        psel[l] = 1'b0; penable[l] = 1'b0;
        if (abort_at == 0) chk("completes", l, 64'(r_rdy_j >= 0), 64'd1);
    endtask

    initial begin
        int ln, gap, hold, ab, sel;
        bit wr;
        logic [9:0] a;
        for (int l = 0; l < 2; l++) begin
            psel[l] = 1'b1; penable[l] = 1'b0; pwrite[l] = 1'b1; paddr[l] = '0; pwdata[l] = '0;
        end
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        chk_on = 1'b1;
        #1;
        for (int l = 0; l < 2; l++) begin
            chk("rst_ctrl", l, 64'({pready[l], pslverr[l], wr_en[l], rd_en[l]}), 64'd0);
            chk("rst_data", l, 64'(prdata[l] | wdata[l] | 32'(addr[l])), 64'd0);
        end
        repeat (3) @(negedge clk);
        for (int l = 0; l < 2; l++) psel[l] = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ctrl", 0, 64'({pready[0], wr_en[0], rd_en[0], pready[1], wr_en[1], rd_en[1]}), 64'd0);

        xfer(0, 1'b1, 10'h000, 32'habababab, 1, 0);
        chk("wr_strobe_cycle", 0, 64'(r_strb_j), 64'd1);
        chk("wr_strobe_count", 0, 64'(r_strb_cnt), 64'd1);
        chk("wr_strobe_kind", 0, 64'(r_strb_rd), 64'd0);
        chk("wr_strobe_addr", 0, 64'(r_strb_addr), 64'h0);
        chk("wr_strobe_wdata", 0, 64'(r_strb_wdata), 64'habababab);
        chk("wr_pready_cycle", 0, 64'(r_rdy_j), 64'd4);
        chk("wr_pslverr", 0, 64'(r_pslverr), 64'd0);
        @(negedge clk);

        xfer(0, 1'b0, 10'h004, 32'h0, 1, 0);
        chk("rd_strobe_kind", 0, 64'(r_strb_rd), 64'd1);
        chk("rd_strobe_count", 0, 64'(r_strb_cnt), 64'd1);
        chk("rd_pready_cycle", 0, 64'(r_rdy_j), 64'd4);
        chk("rd_prdata", 0, 64'(r_prdata), 64'h12345678);
        @(negedge clk);
        chk("rd_pready_drop", 0, 64'(pready[0]), 64'd0);
        chk("rd_prdata_held", 0, 64'(prdata[0]), 64'h12345678);

        xfer(0, 1'b1, 10'h006, 32'hdeadbeef, 1, 0);
        chk("misalign_strobes", 0, 64'(r_strb_cnt), 64'd0);
        chk("misalign_pslverr", 0, 64'(r_pslverr), 64'd1);
        chk("misalign_latency", 0, 64'(r_rdy_j), 64'd4);
        @(negedge clk);

        xfer(0, 1'b0, 10'h010, 32'h0, 1, 0);
        chk("range_strobes", 0, 64'(r_strb_cnt), 64'd0);
        chk("range_prdata", 0, 64'(r_prdata), 64'd0);
        chk("range_pslverr", 0, 64'(r_pslverr), 64'd1);
        @(negedge clk);

        xfer(1, 1'b1, 10'h008, 32'h600dcafe, 1, 0);
        chk("wait3_strobe_cycle", 1, 64'(r_strb_j), 64'd4);
        chk("wait3_pready_cycle", 1, 64'(r_rdy_j), 64'd7);
        @(negedge clk);

        xfer(1, 1'b1, 10'h004, 32'h0badf00d, 1, 3);
        chk("abort_strobes", 1, 64'(r_strb_cnt), 64'd0);
        chk("abort_no_pready", 1, 64'(r_rdy_j < 0), 64'd1);

        psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'h008; pwdata[0] = 32'h5555aaaa;
        @(negedge clk);
        penable[0] = 1'b1;
        @(negedge clk);
        chk("acc_wr_en", 0, 64'(wr_en[0]), 64'd1);
        #2 rst_n = 1'b0;
        psel[0] = 1'b0; penable[0] = 1'b0;
        #1;
        chk("midrst_wr_en", 0, 64'(wr_en[0]), 64'd0);
        chk("midrst_outs", 0, 64'({pready[0], pslverr[0], rd_en[0]}) | 64'(addr[0]) | 64'(wdata[0]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_pready", 0, 64'(pready[0]), 64'd0);

        xfer(0, 1'b0, 10'h00C, 32'h0, 1, 0);
        chk("post_rst_rd", 0, 64'(r_prdata), 64'hC0DE000C);
        chk("post_rst_latency", 0, 64'(r_rdy_j), 64'd4);
        chk("post_rst_pslverr", 0, 64'(r_pslverr), 64'd0);

        gap = 0;
        for (int n = 0; n < 240; n++) begin
            ln  = int'($urandom_range(0, 1));
            wr  = 1'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 7));
            if (sel == 0)      a = 10'($urandom);
            else if (sel == 1) a = 10'($urandom_range(4, 255) * 4);
            else               a = 10'($urandom_range(0, 3) * 4);
            hold = (gap == 0) ? 2 : 1;
            ab = 0;
            if (hold == 1 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, wc(ln) + 3));
            xfer(ln, wr, a, $urandom, hold, ab);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
